// File: rtl/count_seq_ctrl_if.sv
// Host/counter signal bundle for count_seq_ctrl.
// The master drives the job request and the counter's output; the slave is the controller.
interface count_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] stop_val;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] ctr_cnt;
  logic [WIDTH-1:0] ctr_inputs;
  logic             ctr_redge;
  logic             ctr_reset;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, start_val, stop_val, pause, abort, ctr_cnt,
    input  ctr_inputs, ctr_redge, ctr_reset, busy, done, err
  );

  modport slave (
    input  start, start_val, stop_val, pause, abort, ctr_cnt,
    output ctr_inputs, ctr_redge, ctr_reset, busy, done, err
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// Run controller for a load-and-increment counter: loads start_val, steps to stop_val, reports done.
// Optional expected-value checker enabled by defining COUNT_SEQ_CHECK_EN.
//   state   | meaning
//   S_IDLE  | waiting for start; counter untouched
//   S_LOAD  | counter loaded with start_val (fed start_val-1 with step enable)
//   S_RUN   | counter steps via feedback until it equals stop_val; pause holds
//   S_DONE  | one-cycle completion pulse
//   S_ABORT | one-cycle synchronous clear of the counter
module count_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input logic              clock,
  input logic              reset_n,
  count_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_ABORT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_start_val;
  logic [WIDTH-1:0] r_stop_val;
  logic             w_at_stop;
  logic             w_accept;
  logic [WIDTH-1:0] w_inputs;
  logic             w_redge;
  logic             w_reset;
  logic             w_busy;
  logic             w_done;

  assign w_at_stop = (bus.ctr_cnt == r_stop_val);
  assign w_accept  = (r_state == S_IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_start_val <= '0;
      r_stop_val  <= '0;
    end else if (w_accept) begin
      r_start_val <= bus.start_val;
      r_stop_val  <= bus.stop_val;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.abort) w_next = S_ABORT;
               else if (bus.start) w_next = S_LOAD;
      S_LOAD:  w_next = bus.abort ? S_ABORT : S_RUN;
      // abort wins even on the cycle the counter reaches stop_val
      S_RUN:   if (bus.abort) w_next = S_ABORT;
               else if (w_at_stop) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ABORT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_inputs = '0;
    w_redge  = 1'b0;
    w_reset  = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_inputs = r_start_val - WIDTH'(1);
        w_redge  = 1'b1;
        w_busy   = 1'b1;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (!w_at_stop) begin
          w_inputs = bus.ctr_cnt;
          w_redge  = !bus.pause && !bus.abort;
        end
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      S_ABORT: w_reset = 1'b1;
      default: ;
    endcase
  end

  assign bus.ctr_inputs = w_inputs;
  assign bus.ctr_redge  = w_redge;
  assign bus.ctr_reset  = w_reset;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

`ifdef COUNT_SEQ_CHECK_EN
  logic [WIDTH-1:0] r_exp;
  logic             r_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_exp <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_LOAD) begin
        r_exp <= r_start_val;
      end else if ((r_state == S_RUN) && w_redge) begin
        r_exp <= r_exp + WIDTH'(1);
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if ((r_state == S_RUN) && (bus.ctr_cnt != r_exp)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: random jobs with pause/abort/stray start, predicted by job arithmetic.
// Includes a behavioural counter so the controller closes its loop.
module tb_count_seq_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   skip_at;
  int   n_cmp;
  int   n_bad;
  int   blen;
  int   m_last;

  typedef struct {
    bit is_done;
    int cyc;
    int cnt;
    int blen;
  } ev_t;

  ev_t sb[$];

  count_seq_ctrl_if #(.WIDTH(4)) bus ();

  count_seq_ctrl #(.WIDTH(4)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // counter datapath; skip_at injects a one-time double step for the checker test
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.ctr_cnt <= '0;
    else if (bus.ctr_reset) bus.ctr_cnt <= '0;
    else if (bus.ctr_redge)
      bus.ctr_cnt <= bus.ctr_inputs + ((int'(bus.ctr_cnt) == skip_at) ? 4'd2 : 4'd1);
  end

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      blen = 0;
    end else begin
      if (bus.busy) blen = blen + 1;
      else blen = 0;
      if (bus.done || bus.ctr_reset) begin
        chk("event_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          ev_t e;
          e = sb.pop_front();
          chk("event_kind", int'(bus.done), int'(e.is_done));
          chk("event_cycle", cyc, e.cyc);
          chk("event_cnt", int'(bus.ctr_cnt), e.cnt);
          if (e.is_done) chk("busy_len", blen, e.blen);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_redge"}, int'(bus.ctr_redge), 0);
    chk({tag, "_creset"}, int'(bus.ctr_reset), 0);
    chk({tag, "_inputs"}, int'(bus.ctr_inputs), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
  endtask

  // mode 0: normal job, 1: abort in RUN at offset a, 2: abort together with start in IDLE
  task automatic run_job(input logic [3:0] sv, input logic [3:0] ev, input int p, input int k,
                         input bit lp, input int mode, input int a, input bit stray,
                         input bit dab, input int adj);
    logic [3:0] dd;
    logic [3:0] acnt;
    int d, ext, len, c, scyc;
    ev_t e;
    dd   = ev - sv;
    d    = int'(dd);
    acnt = sv + 4'(a);
    ext  = (k < d) ? p : 0;
    @(negedge clk);
    c = cyc;
    bus.start     = 1'b1;
    bus.start_val = sv;
    bus.stop_val  = ev;
    bus.abort     = (mode == 2);
    if (mode == 2) begin
      e = '{is_done: 1'b0, cyc: c + 1, cnt: m_last, blen: 0};
      m_last = 0;
      len = 2;
    end else if (mode == 1) begin
      e = '{is_done: 1'b0, cyc: c + 3 + a, cnt: int'(acnt), blen: 0};
      m_last = 0;
      len = 4 + a;
    end else begin
      e = '{is_done: 1'b1, cyc: c + 3 + d + ext - adj, cnt: int'(ev), blen: 3 + d + ext - adj};
      m_last = int'(ev);
      len = 4 + d + ext - adj;
    end
    sb.push_back(e);
    scyc = c + $urandom_range(1, 3 + d + ext - adj);
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.pause     = 1'b0;
      bus.start_val = 4'($urandom);
      bus.stop_val  = 4'($urandom);
      if (mode == 1 && i == 2 + a) bus.abort = 1'b1;
      if (mode == 0) begin
        bus.pause = (i >= 2 + k && i < 2 + k + p) || (lp && i == 1);
        if (stray && c + i == scyc) bus.start = 1'b1;
        if (dab && i == len - 1) bus.abort = 1'b1;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pause = 1'b0;
  endtask

  initial begin
    logic [3:0] sv, ev, dd;
    int d, m, mode;
    cyc = 0; n_cmp = 0; n_bad = 0; blen = 0; m_last = 0; skip_at = -1;
    bus.start = 1'b0; bus.start_val = '0; bus.stop_val = '0;
    bus.pause = 1'b0; bus.abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    run_job(4'd3, 4'd7, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    run_job(4'd14, 4'd1, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    chk("hold_after_wrap", int'(bus.ctr_cnt), 1);
    run_job(4'd5, 4'd5, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    chk("hold_after_equal", int'(bus.ctr_cnt), 5);
    run_job(4'd0, 4'd9, 2, 4, 1'b1, 0, 0, 1'b0, 1'b0, 0);
    run_job(4'd0, 4'd9, 0, 0, 1'b0, 1, 6, 1'b0, 1'b0, 0);
    chk("cnt_cleared_by_abort", int'(bus.ctr_cnt), 0);
    run_job(4'd2, 4'd8, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    run_job(4'd4, 4'd6, 0, 0, 1'b0, 2, 0, 1'b0, 1'b0, 0);
    chk("idle_abort_clear", int'(bus.busy), 0);

    // reset in the middle of a run
    @(negedge clk);
    bus.start = 1'b1; bus.start_val = 4'd0; bus.stop_val = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && bus.ctr_cnt != 4'd5; i++) @(negedge clk);
    chk("reset_wait_cnt5", int'(bus.ctr_cnt), 5);
    chk("busy_before_reset", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("midrun_reset");
    m_last = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // counter skips a value mid-run
    skip_at = 3;
    run_job(4'd0, 4'd9, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1);
    skip_at = -1;
    repeat (3) @(negedge clk);
`ifdef COUNT_SEQ_CHECK_EN
    chk("err_sticky", int'(bus.err), 1);
`else
    chk("err_sticky", int'(bus.err), 0);
`endif
    run_job(4'd2, 4'd4, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    chk("err_cleared_by_start", int'(bus.err), 0);

    repeat (60) begin
      sv = 4'($urandom);
      ev = 4'($urandom);
      dd = ev - sv;
      d  = int'(dd);
      m  = $urandom_range(0, 9);
      mode = (m < 6) ? 0 : (m < 8) ? 1 : 2;
      run_job(sv, ev, $urandom_range(0, 3), $urandom_range(0, d), 1'($urandom_range(0, 1)),
              mode, $urandom_range(0, d), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      chk("err_random", int'(bus.err), 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", int'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
